// File: rtl/pearson_pkg.sv
// pearson_pkg: shared constants and state type for the Pearson hash controller.
// No ports; imported by pearson_msg_buf and pearson_hash_ctrl.
package pearson_pkg;
    localparam int BYTE_W         = 8;
    localparam int TABLE_DEPTH    = 256;
    localparam int DEF_HASH_BYTES = 4;
    localparam int DEF_MAX_LEN    = 16;

    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/pearson_msg_buf.sv
// pearson_msg_buf: MAX_LEN x 8 message store with byte count and overflow flag.
// Ports: clk, rst (async, active-high); wr_en/wr_data append a byte (dropped
// and flagged in ovf once full); clr empties the buffer; rd_idx/rd_data give a
// combinational random-access read; count is the number of bytes stored.
module pearson_msg_buf
    import pearson_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int IDX_W   = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              clr,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [BYTE_W-1:0] rd_data,
    output logic [LEN_W-1:0]  count,
    output logic              ovf
);
    logic [BYTE_W-1:0] mem [2**IDX_W];
    logic              room;

    assign room    = count < LEN_W'(MAX_LEN);
    assign rd_data = mem[rd_idx];

    // Payload needs no reset: only the first count entries are ever read.
    always_ff @(posedge clk)
        if (wr_en && room) mem[count[IDX_W-1:0]] <= wr_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (wr_en) begin
            if (room) count <= count + LEN_W'(1);
            else      ovf   <= 1'b1;
        end
endmodule

// File: rtl/pearson_hash_ctrl.sv
// pearson_hash_ctrl: multi-byte Pearson hash sequencer over an external 256x8 table.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data/in_last message
// byte stream; tbl_en/tbl_addr/tbl_rdata synchronous-read table port (data one
// cycle after tbl_en); out_valid/out_ready digest handshake carrying out_digest
// (byte j at [8j+7:8j]), out_len (bytes stored) and out_err (message truncated).
module pearson_hash_ctrl
    import pearson_pkg::*;
#(
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int HASH_BYTES = DEF_HASH_BYTES,
    parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BYTE_W-1:0]            in_data,
    input  logic                         in_last,
    output logic                         tbl_en,
    output logic [BYTE_W-1:0]            tbl_addr,
    input  logic [BYTE_W-1:0]            tbl_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BYTE_W*HASH_BYTES-1:0] out_digest,
    output logic [LEN_W-1:0]             out_len,
    output logic                         out_err
);
    localparam int IDX_W = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int J_W   = $clog2(HASH_BYTES + 1);

    state_t            state;
    logic [J_W-1:0]    j;
    logic [IDX_W-1:0]  k;
    logic [IDX_W-1:0]  last_k;
    logic [BYTE_W-1:0] x;
    logic [BYTE_W-1:0] addr_q;

    pearson_msg_buf #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .IDX_W(IDX_W)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid && in_ready),
        .wr_data (in_data),
        .clr     (out_valid && out_ready),
        .rd_idx  (k),
        .rd_data (x),
        .count   (out_len),
        .ovf     (out_err)
    );

    assign last_k = IDX_W'(out_len - LEN_W'(1));
    // j == HASH_BYTES is the drain cycle: nothing issued, last byte captured.
    assign tbl_en = state == RUN && j != J_W'(HASH_BYTES);
    // The chained address must come straight from tbl_rdata so that one
    // lookup issues per cycle; addr_q only keeps the bus steady when idle.
    assign tbl_addr = !tbl_en ? addr_q : k == '0 ? x + BYTE_W'(j) : tbl_rdata ^ x;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= LOAD;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_digest <= '0;
            j          <= '0;
            k          <= '0;
            addr_q     <= '0;
        end else begin
            addr_q <= tbl_addr;
            case (state)
                LOAD: if (in_valid && in_last) begin
                    state    <= RUN;
                    in_ready <= 1'b0;
                    j        <= '0;
                    k        <= '0;
                end
                RUN: begin
                    // At k==0 the data returning is the final lookup of byte j-1.
                    for (int b = 0; b < HASH_BYTES; b++)
                        if (k == '0 && j == J_W'(b + 1)) out_digest[BYTE_W*b +: BYTE_W] <= tbl_rdata;
                    if (j == J_W'(HASH_BYTES)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else if (k == last_k) begin
                        k <= '0;
                        j <= j + J_W'(1);
                    end else begin
                        k <= k + IDX_W'(1);
                    end
                end
                DONE: if (out_ready) begin
                    state      <= LOAD;
                    out_valid  <= 1'b0;
                    in_ready   <= 1'b1;
                    out_digest <= '0;
                end
                default: state <= LOAD;
            endcase
        end
endmodule

// File: tb/tb_pearson_hash_ctrl.sv
// tb_pearson_hash_ctrl: randomized self-checking bench with a sync-read table model.
module tb_pearson_hash_ctrl;
    localparam int M = 16;
    localparam int H = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, tbl_en, out_valid, out_err;
    logic [7:0]  tbl_addr, tbl_rdata;
    logic [31:0] out_digest;
    logic [4:0]  out_len;

    logic [7:0] tbl [256];
    logic [7:0] msg [$];
    logic [7:0] alog [$];
    int cyc = 0, ens = 0, cmp = 0, bad = 0, c_e = 0;

    pearson_hash_ctrl #(.MAX_LEN(M), .HASH_BYTES(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .tbl_en(tbl_en), .tbl_addr(tbl_addr),
        .tbl_rdata(tbl_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_digest(out_digest), .out_len(out_len), .out_err(out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tbl_en) tbl_rdata <= tbl[tbl_addr];
    end

    always @(negedge clk)
        if (tbl_en) begin
            ens++;
            alog.push_back(tbl_addr);
        end

    function automatic logic [31:0] model();
        int n;
        logic [7:0] h;
        logic [31:0] d;
        n = msg.size() > M ? M : msg.size();
        d = '0;
        for (int jj = 0; jj < H; jj++) begin
            h = tbl[8'(int'(msg[0]) + jj)];
            for (int i = 1; i < n; i++) h = tbl[h ^ msg[i]];
            d[8*jj +: 8] = h;
        end
        return d;
    endfunction

    task automatic send_msg();
        for (int i = 0; i < msg.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = (i == msg.size() - 1);
        end
        @(negedge clk);
        c_e      = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit ok);
        int n = 0;
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - c_e;
        ok  = out_valid;
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic rand_msg(input int n);
        msg = {};
        repeat (n) msg.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cmp++;
        if ({in_ready, out_valid, out_err, tbl_en, tbl_addr, out_len, out_digest} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 32'h0}) begin
            bad++;
            $display("FAIL reset_state got rdy=%b vld=%b err=%b en=%b addr=%h len=%0d dig=%h", in_ready, out_valid, out_err, tbl_en, tbl_addr, out_len, out_digest);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int lat, e0;
        bit ok;
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
        msg = {8'h01, 8'h02};
        e0 = ens;
        send_msg();
        wait_out(lat, ok);
        cmp++; if (!ok) begin bad++; $display("FAIL ident_timeout out_valid never rose"); end
        cmp++; if (out_digest !== 32'h06010003) begin bad++; $display("FAIL ident_digest got %h want 06010003", out_digest); end
        cmp++; if (out_len !== 5'd2 || out_err !== 1'b0) begin bad++; $display("FAIL ident_len_err got len=%0d err=%b want 2/0", out_len, out_err); end
        cmp++; if (lat != 9) begin bad++; $display("FAIL ident_latency got %0d want 9", lat); end
        cmp++; if (ens - e0 != 8) begin bad++; $display("FAIL ident_lookups got %0d want 8", ens - e0); end
        ack();
        cmp++;
        if ({in_ready, out_valid, out_len, out_digest} !== {1'b1, 1'b0, 5'd0, 32'h0}) begin
            bad++;
            $display("FAIL ident_after_ack got rdy=%b vld=%b len=%0d dig=%h", in_ready, out_valid, out_len, out_digest);
        end
    endtask

    task automatic test_seed_wrap();
        int lat, a0;
        bit ok;
        logic [31:0] seq;
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i + 1);
        msg = {8'hFF};
        a0 = alog.size();
        send_msg();
        wait_out(lat, ok);
        cmp++; if (out_digest !== 32'h03020100) begin bad++; $display("FAIL wrap_digest got %h want 03020100", out_digest); end
        cmp++; if (lat != 5) begin bad++; $display("FAIL wrap_latency got %0d want 5", lat); end
        cmp++;
        if (alog.size() - a0 != 4) begin
            bad++;
            $display("FAIL wrap_addr_count got %0d want 4", alog.size() - a0);
        end else begin
            seq = {alog[a0], alog[a0+1], alog[a0+2], alog[a0+3]};
            if (seq !== 32'hFF000102) begin bad++; $display("FAIL wrap_addr_seq got %h want ff000102", seq); end
        end
        ack();
    endtask

    task automatic test_random();
        int lat, e0, n;
        bit ok;
        logic [7:0] t;
        logic [31:0] exp;
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            int r = int'($urandom_range(i, 0));
            t = tbl[i]; tbl[i] = tbl[r]; tbl[r] = t;
        end
        for (int m = 0; m < 25; m++) begin
            n = int'($urandom_range(M, 1));
            rand_msg(n);
            exp = model();
            e0 = ens;
            send_msg();
            wait_out(lat, ok);
            cmp++; if (out_digest !== exp) begin bad++; $display("FAIL rand_digest msg%0d len=%0d got %h want %h", m, n, out_digest, exp); end
            cmp++; if (out_len !== 5'(n) || out_err !== 1'b0) begin bad++; $display("FAIL rand_len_err msg%0d got len=%0d err=%b want %0d/0", m, out_len, out_err, n); end
            cmp++; if (ens - e0 != n * H) begin bad++; $display("FAIL rand_lookups msg%0d got %0d want %0d", m, ens - e0, n * H); end
            cmp++; if (lat != n * H + 1) begin bad++; $display("FAIL rand_latency msg%0d got %0d want %0d", m, lat, n * H + 1); end
            ack();
        end
    endtask

    task automatic test_overflow();
        int lat, e0;
        bit ok;
        logic [31:0] exp;
        rand_msg(20);
        exp = model();
        e0 = ens;
        send_msg();
        wait_out(lat, ok);
        cmp++; if (out_digest !== exp) begin bad++; $display("FAIL ovf_digest got %h want %h", out_digest, exp); end
        cmp++; if (out_len !== 5'd16 || out_err !== 1'b1) begin bad++; $display("FAIL ovf_len_err got len=%0d err=%b want 16/1", out_len, out_err); end
        cmp++; if (ens - e0 != M * H || lat != M * H + 1) begin bad++; $display("FAIL ovf_timing got lookups=%0d lat=%0d want %0d/%0d", ens - e0, lat, M * H, M * H + 1); end
        ack();
        cmp++; if (out_err !== 1'b0 || out_len !== 5'd0) begin bad++; $display("FAIL ovf_cleared got err=%b len=%0d want 0/0", out_err, out_len); end
    endtask

    task automatic test_hold();
        int lat;
        bit ok;
        logic [31:0] exp;
        rand_msg(5);
        exp = model();
        send_msg();
        wait_out(lat, ok);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cmp++;
            if ({out_valid, in_ready, out_len, out_digest} !== {1'b1, 1'b0, 5'd5, exp}) begin
                bad++;
                $display("FAIL hold_stable cyc%0d got vld=%b rdy=%b len=%0d dig=%h want 1/0/5/%h", c, out_valid, in_ready, out_len, out_digest, exp);
            end
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        cmp++; if (out_len !== 5'd5) begin bad++; $display("FAIL hold_no_accept got len=%0d want 5", out_len); end
        ack();
        rand_msg(7);
        exp = model();
        send_msg();
        wait_out(lat, ok);
        cmp++; if (out_digest !== exp || out_len !== 5'd7) begin bad++; $display("FAIL hold_next got dig=%h len=%0d want %h/7", out_digest, out_len, exp); end
        ack();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok;
        logic [31:0] exp;
        rand_msg(8);
        send_msg();
        repeat (5) @(negedge clk);
        cmp++; if (tbl_en !== 1'b1) begin bad++; $display("FAIL midrst_in_run got en=%b want 1", tbl_en); end
        #2 rst = 1'b1;
        #1;
        cmp++;
        if ({in_ready, out_valid, out_err, tbl_en, tbl_addr, out_len, out_digest} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 32'h0}) begin
            bad++;
            $display("FAIL midrst_outputs got rdy=%b vld=%b err=%b en=%b addr=%h len=%0d dig=%h", in_ready, out_valid, out_err, tbl_en, tbl_addr, out_len, out_digest);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        cmp++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_valid got %b want 0", out_valid); end
        rand_msg(6);
        exp = model();
        send_msg();
        wait_out(lat, ok);
        cmp++;
        if (out_digest !== exp || out_len !== 5'd6 || out_err !== 1'b0 || lat != 6 * H + 1) begin
            bad++;
            $display("FAIL midrst_next got dig=%h len=%0d err=%b lat=%0d want %h/6/0/%0d", out_digest, out_len, out_err, lat, exp, 6 * H + 1);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_seed_wrap();
        test_random();
        test_overflow();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule

// File: doc/pearson_hash_ctrl.md
Name: pearson_hash_ctrl

Overview:
Sequencer that computes a multi-byte Pearson hash over a byte message using a single shared 256x8 permutation table. It buffers an incoming message and walks the table once per message byte per hash byte. It packs HASH_BYTES result bytes into a digest delivered over a valid/ready handshake. The table itself is an external synchronous-read memory (ROM or RAM) owned by the parent.

Parameters:
MAX_LEN, 16, maximum message length in bytes (>=1).
HASH_BYTES, 4, number of hash bytes produced (>=1, <=256).
LEN_W, $clog2(MAX_LEN+1), width of length fields.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  message byte valid.
in_ready  out  1  controller can accept a byte.
in_data  in  8  message byte.
in_last  in  1  marks final byte of message.
tbl_en  out  1  table read enable.
tbl_addr  out  8  table read address.
tbl_rdata  in  8  table data, valid exactly one cycle after tbl_en.
out_valid  out  1  digest valid.
out_ready  in  1  consumer accepts digest.
out_digest  out  8*HASH_BYTES  hash byte j at [8j+7:8j].
out_len  out  LEN_W  number of bytes stored (L).
out_err  out  1  message exceeded MAX_LEN and was truncated.

Behaviour:
- Reset (async assert, sync release): state LOAD; in_ready=1; out_valid=0; out_digest=0; out_len=0; out_err=0; tbl_en=0; tbl_addr=0; byte count=0.
- Algorithm per hash byte j: h=T[(x[0]+j) mod 256]; for i=1..L-1: h=T[h ^ x[i]]; digest byte j=h.
- States:
  - LOAD: in_ready=1. Each handshake stores in_data at index=count if count<MAX_LEN, else drops it and sets the error flag. A handshake with in_last goes to RUN, with j=0, i=0.
  - RUN: in_ready=0. One table lookup is issued per cycle. Cycle 0 after the last beat: tbl_addr=x[0]+j. Cycle k (1<=k<L): tbl_addr=tbl_rdata ^ x[k], formed combinationally from the returned data and registered into the address. The lookup returned at cycle L completes byte j into the digest register. The seed for j+1 is issued in that same cycle, so there are no bubbles between bytes. After byte HASH_BYTES-1 completes, go to DONE.
  - DONE: out_valid=1; out_digest, out_len and out_err are held stable. On out_valid&&out_ready, clear the buffer count, digest and error, then go to LOAD.
- Latency: the last-beat handshake lands on edge E. out_valid rises at E+L*HASH_BYTES+1 cycles.
- tbl_en=1 only on cycles issuing an address; tbl_addr is don't-care otherwise but holds its last value.
- All index arithmetic is 8-bit wrap-around. x[0]+j wraps, e.g. 0xFF+1=0x00.
- L=1: each hash byte is a single lookup (T[x0+j]).
- Overflow: L saturates at MAX_LEN and out_err=1. The hash covers the first MAX_LEN bytes only.
- in_last on the first beat is legal (L=1). The protocol has no zero-length message.
- in_valid while in RUN or DONE is ignored (in_ready=0). Upstream must hold its data.
- rst mid-RUN or in DONE aborts immediately. The message and partial digest are discarded and no out_valid is produced.

Decomposition:
- Shared package pearson_pkg: BYTE_W=8, TABLE_DEPTH=256, state enum {LOAD,RUN,DONE}, and the default HASH_BYTES/MAX_LEN constants (shared with the combinational hash and the table ROM).
- Optional sub-module pearson_msg_buf: MAX_LEN x 8 register array with write port, count, overflow flag and a random-access read at index i. The FSM stays in pearson_hash_ctrl.
- The bench supplies a 256x8 sync-read table model.

Test Plan:
- Identity table T[i]=i, HASH_BYTES=4, message {0x01,0x02} -> digest bytes 0x03,0x00,0x01,0x06; out_len=2; out_err=0; out_valid at E+9.
- T[i]=(i+1) mod 256, HASH_BYTES=2, message {0xFF} -> byte0=0x00, byte1=0x01 (seed wrap); tbl_addr sequence 0xFF,0x00.
- Shuffled 256-entry permutation, random messages of length 1..MAX_LEN -> digest matches reference model; exactly L*HASH_BYTES tbl_en pulses per message.
- MAX_LEN=16, send 20 bytes -> out_len=16; out_err=1; digest equals the hash of the first 16 bytes.
- Hold out_ready=0 for 10 cycles in DONE while driving in_valid -> digest stable, in_ready=0, no bytes accepted; release -> LOAD and the next message is hashed correctly.
- Assert rst midway through RUN -> all outputs return to reset values within the same cycle; the following message is hashed correctly with no residue.
